// File: rtl/lc3b_mem_responder_if.sv
// Memory-side bus of the LC-3b CPU/cache interface.
// The mem_err member exists only when MEM_OOR_ERR_EN is defined.
interface lc3b_mem_responder_if;
  // Handshake: the master raises mem_read or mem_write and holds the request,
  // address, byte enables and wdata until it sees mem_resp. mem_resp is a
  // one-cycle pulse, and mem_rdata (plus mem_err) is valid in that cycle.
  // Requests seen during the busy and response cycles are ignored.
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
`ifdef MEM_OOR_ERR_EN
  logic        mem_err;
`endif

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
`ifdef MEM_OOR_ERR_EN
    , input mem_err
`endif
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
`ifdef MEM_OOR_ERR_EN
    , output mem_err
`endif
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency word-array responder for the LC-3b memory handshake.
// Optional MEM_OOR_ERR_EN: flag out-of-range word indices on mem_err instead of wrapping.
module lc3b_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  lc3b_mem_responder_if.slave       bus,
  output logic [1:0]                dbg_state
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;

  logic              cap_write;
  logic [14:0]       cap_word;
  logic [1:0]        cap_be;
  logic [15:0]       cap_wdata;

  logic              cur_write;
  logic [14:0]       cur_word;
  logic [1:0]        cur_be;
  logic [15:0]       cur_wdata;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_oor;
  logic              req;
  logic              commit;

  // Cleared only at time 0; reset leaves the contents alone.
  logic [15:0] mem [DEPTH_WORDS] = '{default: '0};

  assign req       = bus.mem_read | bus.mem_write;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = (LATENCY == 1) ? RESP : BUSY;
          cnt_next   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) state_next = RESP;
        else                  cnt_next   = cnt - CNT_W'(1);
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY = 1 the commit edge is the accept edge, so the live inputs
  // are used while idle and the captured copy afterwards.
  always_comb begin
    cur_write = cap_write;
    cur_word  = cap_word;
    cur_be    = cap_be;
    cur_wdata = cap_wdata;
    if (state == IDLE) begin
      cur_write = bus.mem_write;
      cur_word  = bus.mem_address[15:1];
      cur_be    = bus.mem_byte_enable;
      cur_wdata = bus.mem_wdata;
    end
  end

  assign commit  = (state != RESP) && (state_next == RESP);
  assign cur_idx = cur_word[IDX_W-1:0];

`ifdef MEM_OOR_ERR_EN
  assign cur_oor = ({17'd0, cur_word} >= 32'(DEPTH_WORDS));
`else
  assign cur_oor = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_write     <= 1'b0;
      cap_word      <= '0;
      cap_be        <= '0;
      cap_wdata     <= '0;
      bus.mem_resp  <= 1'b0;
      bus.mem_rdata <= '0;
`ifdef MEM_OOR_ERR_EN
      bus.mem_err   <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      bus.mem_resp <= commit;
      if (state == IDLE && req) begin
        cap_write <= bus.mem_write;
        cap_word  <= bus.mem_address[15:1];
        cap_be    <= bus.mem_byte_enable;
        cap_wdata <= bus.mem_wdata;
      end
      if (commit && !cur_write) bus.mem_rdata <= cur_oor ? 16'h0000 : mem[cur_idx];
`ifdef MEM_OOR_ERR_EN
      bus.mem_err <= commit && cur_oor;
`endif
    end
  end

  // rst_n gates the write so an edge seen while in reset never commits.
  always_ff @(posedge clk) begin
    if (rst_n && commit && cur_write && !cur_oor) begin
      if (cur_be[0]) mem[cur_idx][7:0]  <= cur_wdata[7:0];
      if (cur_be[1]) mem[cur_idx][15:8] <= cur_wdata[15:8];
    end
  end

  logic unused;
  assign unused = &{1'b0, bus.mem_address[0], cur_word};
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder (DEPTH_WORDS = 256, LATENCY = 3).
module tb_lc3b_mem_responder;
  localparam int LAT   = 3;
  localparam int DEPTH = 256;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  lc3b_mem_responder_if bus();

  lc3b_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // {err, rdata} expected for each mem_resp pulse, in order
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.mem_resp === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: mem_resp with nothing outstanding at %0t", $time);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("rdata", {16'd0, bus.mem_rdata}, {16'd0, e[15:0]});
`ifdef MEM_OOR_ERR_EN
        check("mem_err", {31'd0, bus.mem_err}, {31'd0, e[16]});
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        drop;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] be,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic drop, input logic [15:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.be = be; v.addr = addr; v.wdata = wdata;
    v.drop = drop; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 2'b00;
    bus.mem_address     = 16'h0000;
    bus.mem_wdata       = 16'h0000;
  endtask

  task automatic run_txn(input vec_t v);
    int  cyc;
    bit  seen;
    @(negedge clk);
    bus.mem_read        = v.rd;
    bus.mem_write       = v.wr;
    bus.mem_byte_enable = v.be;
    bus.mem_address     = v.addr;
    bus.mem_wdata       = v.wdata;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.mem_resp === 1'b1) seen = 1;
      else if (v.drop && cyc == 1) begin
        // request withdrawn and bus scrambled while busy
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 2'($urandom_range(0, 3));
        bus.mem_address     = 16'($urandom_range(0, 65535));
        bus.mem_wdata       = 16'($urandom_range(0, 65535));
      end
    end
    check("latency", cyc, LAT);
    idle_inputs();
    @(posedge clk); #1;
    check("resp_width", {31'd0, bus.mem_resp}, 32'd0);
  endtask

  vec_t vecs[18];

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    vecs[0]  = mk(0, 1, 2'b11, 16'h0010, 16'hBEEF, 0, 16'h0000, 0);
    vecs[1]  = mk(1, 0, 2'b11, 16'h0010, 16'h0000, 0, 16'hBEEF, 0);
    vecs[2]  = mk(0, 1, 2'b11, 16'h0020, 16'h1234, 0, 16'hBEEF, 0);
    vecs[3]  = mk(0, 1, 2'b01, 16'h0020, 16'hABCD, 0, 16'hBEEF, 0);
    vecs[4]  = mk(1, 0, 2'b11, 16'h0020, 16'h0000, 0, 16'h12CD, 0);
    vecs[5]  = mk(0, 1, 2'b10, 16'h0020, 16'h5600, 0, 16'h12CD, 0);
    vecs[6]  = mk(1, 0, 2'b11, 16'h0020, 16'h0000, 0, 16'h56CD, 0);
    vecs[7]  = mk(0, 1, 2'b00, 16'h0020, 16'hFFFF, 0, 16'h56CD, 0);
    vecs[8]  = mk(1, 0, 2'b11, 16'h0020, 16'h0000, 0, 16'h56CD, 0);
    vecs[9]  = mk(1, 1, 2'b11, 16'h0030, 16'h7777, 0, 16'h56CD, 0);
    vecs[10] = mk(1, 0, 2'b11, 16'h0030, 16'h0000, 0, 16'h7777, 0);
    vecs[11] = mk(1, 0, 2'b11, 16'h0010, 16'h0000, 1, 16'hBEEF, 0);
    vecs[12] = mk(1, 0, 2'b11, 16'h0011, 16'h0000, 0, 16'hBEEF, 0);
    vecs[13] = mk(0, 1, 2'b11, 16'h01FE, 16'hA5A5, 0, 16'hBEEF, 0);
    vecs[14] = mk(1, 0, 2'b11, 16'h01FE, 16'h0000, 0, 16'hA5A5, 0);
`ifdef MEM_OOR_ERR_EN
    vecs[15] = mk(0, 1, 2'b11, 16'h0200, 16'h1111, 0, 16'hA5A5, 1);
    vecs[16] = mk(1, 0, 2'b11, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    vecs[17] = mk(1, 0, 2'b11, 16'h0200, 16'h0000, 0, 16'h0000, 1);
`else
    vecs[15] = mk(0, 1, 2'b11, 16'h0200, 16'h1111, 0, 16'hA5A5, 0);
    vecs[16] = mk(1, 0, 2'b11, 16'h0000, 16'h0000, 0, 16'h1111, 0);
    vecs[17] = mk(1, 0, 2'b11, 16'h0200, 16'h0000, 0, 16'h1111, 0);
`endif

    // reset then idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp", {31'd0, bus.mem_resp}, 32'd0);
    check("rst_rdata", {16'd0, bus.mem_rdata}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_resp", {31'd0, bus.mem_resp}, 32'd0);
      check("idle_rdata", {16'd0, bus.mem_rdata}, 32'd0);
    end

    // table-driven transactions
    for (int i = 0; i < 18; i++) run_txn(vecs[i]);

    // back-to-back: read held through the response is accepted again
    begin
      int gap;
      bit seen;
      @(negedge clk);
      bus.mem_read    = 1'b1;
      bus.mem_address = 16'h0010;
      exp_q.push_back({1'b0, 16'hBEEF});
      exp_q.push_back({1'b0, 16'hBEEF});
      gap = 0; seen = 0;
      while (!seen && gap < 20) begin
        @(posedge clk); #1; gap++;
        if (bus.mem_resp === 1'b1) seen = 1;
      end
      check("b2b_first", gap, LAT);
      gap = 0; seen = 0;
      while (!seen && gap < 20) begin
        @(posedge clk); #1; gap++;
        if (bus.mem_resp === 1'b1) seen = 1;
      end
      check("b2b_second", gap, LAT + 1);
      idle_inputs();
      @(posedge clk); #1;
      check("b2b_width", {31'd0, bus.mem_resp}, 32'd0);
    end

    // reset mid-flight: write is aborted, no response
    @(negedge clk);
    bus.mem_write       = 1'b1;
    bus.mem_byte_enable = 2'b11;
    bus.mem_address     = 16'h0040;
    bus.mem_wdata       = 16'hFFFF;
    @(posedge clk); #1;
    check("mid_busy", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_resp", {31'd0, bus.mem_resp}, 32'd0);
      check("mid_state", {30'd0, dbg_state}, 32'd0);
    end
    check("mid_rdata", {16'd0, bus.mem_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #1;
      check("post_rst_resp", {31'd0, bus.mem_resp}, 32'd0);
    end
    run_txn(mk(1, 0, 2'b11, 16'h0040, 16'h0000, 0, 16'h0000, 0));

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
